// File: rtl/ann_layer_seq_if.sv
// Stream bundle of the layer sequencer: input vector, weight/bias feed and result output.
interface ann_layer_seq_if #(
    parameter int DW    = 8,
    parameter int N_OUT = 3
);
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] value;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] weight;
    logic [DW-1:0] bias;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic [IW-1:0] out_idx;

    modport master (
        output in_valid, value, w_valid, weight, bias, out_ready,
        input  in_ready, w_ready, out_valid, result, out_idx
    );

    modport slave (
        input  in_valid, value, w_valid, weight, bias, out_ready,
        output in_ready, w_ready, out_valid, result, out_idx
    );
endinterface

// File: rtl/ann_layer_seq.sv
// One fully connected layer of N_OUT neurons over N_IN inputs on a single time-shared MAC.
// state | meaning
// IDLE  | waiting for start      LOAD | filling input buffer   MAC | acc += x[i]*w
// BIAS  | add bias, activate     OUT  | result offered          DONE | one-cycle end pulse
module ann_layer_seq #(
    parameter int DW    = 8,
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int FRAC  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           relu,
    ann_layer_seq_if.slave bus,
    output logic           busy,
    output logic           done
);
    localparam int ACC_W = 2*DW + $clog2(N_IN) + 1;
    localparam int II_W  = $clog2(N_IN);
    localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [II_W-1:0] I_LAST = II_W'(N_IN - 1);
    localparam logic [IW-1:0]   J_LAST = IW'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_MAC  = 3'd2;
    localparam logic [2:0] ST_BIAS = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [2:0]              state;
    logic [II_W-1:0]         i_cnt;
    logic [IW-1:0]           j_cnt;
    logic                    relu_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [DW-1:0]    vec_q [N_IN];
    logic [DW-1:0]           result_q;
    logic [IW-1:0]           idx_q;

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_b;
    logic signed [ACC_W-1:0] t_val;
    logic [DW-1:0]           act;

    always_comb begin
        prod     = (2*DW)'(vec_q[i_cnt]) * (2*DW)'($signed(bus.weight));
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        bias_ext = {{(ACC_W-DW){bus.bias[DW-1]}}, bus.bias};
        acc_b    = acc + (bias_ext <<< FRAC);
        t_val    = acc_b >>> FRAC;
        // Clamp rather than wrap; ReLU applies after the clamp.
        if (t_val > SAT_HI)
            act = SAT_HI[DW-1:0];
        else if (t_val < SAT_LO)
            act = SAT_LO[DW-1:0];
        else
            act = t_val[DW-1:0];
        if (relu_q && t_val[ACC_W-1])
            act = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            i_cnt    <= '0;
            j_cnt    <= '0;
            relu_q   <= 1'b0;
            acc      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            for (int k = 0; k < N_IN; k++)
                vec_q[k] <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state  <= ST_LOAD;
                    i_cnt  <= '0;
                    j_cnt  <= '0;
                    relu_q <= relu;
                end
                ST_LOAD: if (bus.in_valid) begin
                    vec_q[i_cnt] <= $signed(bus.value);
                    if (i_cnt == I_LAST) begin
                        i_cnt <= '0;
                        acc   <= '0;
                        state <= ST_MAC;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                ST_MAC: if (bus.w_valid) begin
                    acc <= acc + prod_ext;
                    if (i_cnt == I_LAST) begin
                        i_cnt <= '0;
                        state <= ST_BIAS;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                ST_BIAS: if (bus.w_valid) begin
                    acc      <= acc_b;
                    result_q <= act;
                    idx_q    <= j_cnt;
                    state    <= ST_OUT;
                end
                ST_OUT: if (bus.out_ready) begin
                    if (j_cnt == J_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                        i_cnt <= '0;
                        acc   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_LOAD);
    assign bus.w_ready   = (state == ST_MAC) || (state == ST_BIAS);
    assign bus.out_valid = (state == ST_OUT);
    assign bus.result    = result_q;
    assign bus.out_idx   = idx_q;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
endmodule

// File: tb/tb_ann_layer_seq.sv
// Bench for ann_layer_seq: scoreboard of expected neuron outputs, main build plus a 2x1 build.
module tb_ann_layer_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic start, relu, busy, done;
    logic start1, relu1, busy1, done1;

    ann_layer_seq_if #(.DW(8), .N_OUT(3)) bus ();
    ann_layer_seq_if #(.DW(8), .N_OUT(1)) bus1 ();

    ann_layer_seq #(.DW(8), .N_IN(4), .N_OUT(3), .FRAC(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .relu(relu),
        .bus(bus), .busy(busy), .done(done)
    );

    ann_layer_seq #(.DW(8), .N_IN(2), .N_OUT(1), .FRAC(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .relu(relu1),
        .bus(bus1), .busy(busy1), .done(done1)
    );

    typedef struct {
        int res;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp1_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    int done_cnt = 0, done1_cnt = 0;
    int done_cyc = 0, load_cyc = 0;
    int tmo = 0;
    logic busy_d = 1'b0;

    int vals [4];
    int wts  [3][4];
    int bs   [3];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int acc, input bit r);
        int t;
        t = acc >>> 4;
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        if (r && t < 0) t = 0;
        return t;
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_d) load_cyc = cyc_n;
        busy_d = busy;
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (done1) done1_cnt++;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0)
                check("sb_under", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("result", int'($signed(bus.result)), e.res);
                check("out_idx", int'(bus.out_idx), e.idx);
            end
        end
        if (bus1.out_valid && bus1.out_ready) begin
            if (exp1_q.size() == 0)
                check("sb1_under", exp1_q.size(), 1);
            else begin
                e = exp1_q.pop_front();
                check("result1", int'($signed(bus1.result)), e.res);
                check("out_idx1", int'(bus1.out_idx), e.idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_val(input int v, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        bus.in_valid = 1'b1;
        bus.value    = 8'(v);
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) tmo++;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic put_w(input int w, input int b, input bit is_bias, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        bus.w_valid = 1'b1;
        bus.weight  = is_bias ? 8'($urandom) : 8'(w);
        bus.bias    = is_bias ? 8'(b) : 8'($urandom);
        @(negedge clk);
        while (!bus.w_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) tmo++;
        tick();
        bus.w_valid = 1'b0;
    endtask

    task automatic hold_out();
        int n = 0;
        int bad = 0;
        logic [7:0] r;
        logic [1:0] x;
        @(negedge clk);
        while (!bus.out_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) tmo++;
        r = bus.result;
        x = bus.out_idx;
        repeat (10) begin
            @(negedge clk);
            if (!bus.out_valid || bus.result !== r || bus.out_idx !== x || bus.w_ready || bus.in_ready)
                bad++;
        end
        check("bp_hold", bad, 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        if (n >= 40) tmo++;
    endtask

    task automatic run(input bit r, input bit gaps, input bit bp, input bit poke_start);
        int acc;
        done_cnt      = 0;
        bus.out_ready = !bp;
        start = 1'b1;
        relu  = r;
        tick();
        start = 1'b0;
        relu  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) put_val(vals[i], gaps);
        if (poke_start) start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            acc = 0;
            for (int i = 0; i < 4; i++) begin
                acc += vals[i] * wts[j][i];
                put_w(wts[j][i], 0, 1'b0, gaps);
            end
            acc += bs[j] * 16;
            exp_q.push_back('{res: model(acc, r), idx: j});
            put_w(0, bs[j], 1'b1, gaps);
            if (bp) hold_out();
        end
        start = 1'b0;
        wait_idle();
        bus.out_ready = 1'b1;
        check("done_cnt", done_cnt, 1);
        check("sb_empty", exp_q.size(), 0);
    endtask

    task automatic set_t1();
        for (int i = 0; i < 4; i++) begin
            vals[i]   = 16;
            wts[0][i] = 16;
            wts[1][i] = -16;
            wts[2][i] = -16;
        end
        bs = '{0, 0, 0};
    endtask

    task automatic wait1(input int which);
        int n = 0;
        @(negedge clk);
        while (!((which == 0) ? bus1.in_ready : bus1.w_ready) && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) tmo++;
        tick();
    endtask

    task automatic run1(input bit r);
        int v1 [2];
        int n = 0;
        v1 = '{-8, 8};
        done1_cnt      = 0;
        bus1.out_ready = 1'b1;
        start1 = 1'b1;
        relu1  = r;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus1.in_valid = 1'b1;
            bus1.value    = 8'(v1[k]);
            wait1(0);
            bus1.in_valid = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            bus1.w_valid = 1'b1;
            bus1.weight  = 8'd16;
            wait1(1);
        end
        exp1_q.push_back('{res: model(-8*16 + 8*16 + (-2)*16, r), idx: 0});
        bus1.bias = 8'(-2);
        wait1(1);
        bus1.w_valid = 1'b0;
        while (busy1 && n < 40) begin
            n++;
            tick();
        end
        if (n >= 40) tmo++;
        check("done1_cnt", done1_cnt, 1);
        check("sb1_empty", exp1_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_in_ready"}, int'(bus.in_ready), 0);
        check({tag, "_w_ready"}, int'(bus.w_ready), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_result"}, int'(bus.result), 0);
        check({tag, "_out_idx"}, int'(bus.out_idx), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; relu = 0; start1 = 0; relu1 = 0;
        bus.in_valid = 0; bus.value = '0; bus.w_valid = 0; bus.weight = '0;
        bus.bias = '0; bus.out_ready = 1;
        bus1.in_valid = 0; bus1.value = '0; bus1.w_valid = 0; bus1.weight = '0;
        bus1.bias = '0; bus1.out_ready = 1;

        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b1;
        tick();

        set_t1();
        run(1'b0, 1'b0, 1'b0, 1'b0);
        check("load_to_done", done_cyc - load_cyc + 1, 23);
        run(1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            vals[i]   = 127;
            wts[0][i] = 127;
            wts[1][i] = -128;
            wts[2][i] = 0;
        end
        bs = '{0, 0, 127};
        run(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vals[i]   = 16;
            wts[0][i] = 16;
            wts[1][i] = 16;
            wts[2][i] = (i == 3) ? 0 : -1;
        end
        bs = '{1, -128, 0};
        run(1'b0, 1'b0, 1'b0, 1'b0);

        set_t1();
        run(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                vals[i] = int'($urandom_range(0, 255)) - 128;
                for (int j = 0; j < 3; j++) wts[j][i] = int'($urandom_range(0, 255)) - 128;
            end
            for (int j = 0; j < 3; j++) bs[j] = int'($urandom_range(0, 255)) - 128;
            run(1'(k), 1'b1, 1'(k == 2), 1'b0);
        end

        set_t1();
        start = 1'b1; relu = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) put_val(vals[i], 1'b0);
        for (int i = 0; i < 4; i++) put_w(wts[0][i], 0, 1'b0, 1'b0);
        exp_q.push_back('{res: 64, idx: 0});
        put_w(0, 0, 1'b1, 1'b0);
        put_w(wts[1][0], 0, 1'b0, 1'b0);
        put_w(wts[1][1], 0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_quiet("midrun_rst");
        check("rst_sb_empty", exp_q.size(), 0);
        tick();
        rst = 1'b1;
        tick();
        run(1'b0, 1'b0, 1'b0, 1'b1);

        run1(1'b0);
        run1(1'b1);

        check("timeouts", tmo, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
